// File: rtl/xbus_arb.sv
// xbus_arb: two-master arbiter for the shared data bus in front of the
// address decoder. Master 0 is the controller, master 1 the loader/DMA.
// One access at a time; round-robin with a burst cap on ties.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | bus free, arbitrate pending requests each cycle
//  ACC   | s_sel driven for ACC_CYC cycles with the latched owner fields
//  DONE  | owner ack pulses this cycle, gnt still held
module xbus_arb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 13,
  parameter int ACC_CYC   = 1,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              s_sel,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              busy
);

  localparam int CNT_W  = $clog2(ACC_CYC) + 1;
  localparam int STRK_W = $clog2(BURST_MAX) + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACC_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(BURST_MAX);
  localparam logic [STRK_W-1:0] STRK_ONE = STRK_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              owner;
  logic              last_owner;
  logic [STRK_W-1:0] streak;
  logic [STRK_W-1:0] streak_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              pick;
  logic              grant;
  logic              acc_last;

  assign grant    = (state == ST_IDLE) && (m0_req || m1_req);
  assign acc_last = (state == ST_ACC) && (cnt == CNT_LAST);

  // Arbitration: lone requester always wins; on a tie keep the last owner
  // while its streak is live and below the cap. streak==0 only after reset
  // and means "no history", so the tie goes away from last_owner (=1), i.e.
  // master 0 wins the very first tie.
  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req) begin
      if ((streak != '0) && (streak < STRK_MAX)) pick = last_owner;
      else                                       pick = ~last_owner;
    end else if (m1_req) begin
      pick = 1'b1;
    end
  end

  // Streak update for the master being granted (saturates at the cap).
  always_comb begin
    streak_nxt = streak;
    if (pick == last_owner) begin
      if (streak < STRK_MAX) streak_nxt = streak + STRK_ONE;
    end else begin
      streak_nxt = STRK_ONE;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (m0_req || m1_req) state_nxt = ST_ACC;
      ST_ACC:  if (cnt == CNT_LAST)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; busy mirrors "not IDLE" as a registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
    end
  end

  // Arbitration history and current owner, updated only on a grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      streak     <= '0;
    end else if (grant) begin
      owner      <= pick;
      last_owner <= pick;
      streak     <= streak_nxt;
    end
  end

  // Access-length counter: cleared at grant, counts while in ACC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (grant) begin
      cnt <= '0;
    end else if (state == ST_ACC) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Shared bus drive: owner fields latched at grant, select dropped at the
  // end of the access; address and write data hold their last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_sel   <= 1'b0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else if (grant) begin
      s_sel   <= 1'b1;
      s_we    <= pick ? m1_we    : m0_we;
      s_addr  <= pick ? m1_addr  : m0_addr;
      s_wdata <= pick ? m1_wdata : m0_wdata;
    end else if (acc_last) begin
      s_sel   <= 1'b0;
      s_we    <= 1'b0;
    end
  end

  // Read data capture on the last ACC cycle of a read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (acc_last && !s_we) begin
      rdata <= s_rdata;
    end
  end

  // Grant / ack handshake towards the masters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_gnt <= 1'b0;
      m1_gnt <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
    end else if (grant) begin
      m0_gnt <= ~pick;
      m1_gnt <= pick;
    end else if (acc_last) begin
      m0_ack <= ~owner;
      m1_ack <= owner;
    end else if (state == ST_DONE) begin
      m0_gnt <= 1'b0;
      m1_gnt <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xbus_arb.sv
// Directed bench for xbus_arb: instance "a" uses ACC_CYC=1, instance "b"
// uses ACC_CYC=3; both share clock, reset and master/decoder inputs.
module tb_xbus_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [12:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [12:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic [31:0] s_rdata = '0;

  logic        a_m0_gnt, a_m0_ack, a_m1_gnt, a_m1_ack, a_s_sel, a_s_we, a_busy;
  logic [31:0] a_rdata, a_s_wdata;
  logic [12:0] a_s_addr;
  logic        b_m0_gnt, b_m0_ack, b_m1_gnt, b_m1_ack, b_s_sel, b_s_we, b_busy;
  logic [31:0] b_rdata, b_s_wdata;
  logic [12:0] b_s_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xbus_arb #(.DATA_W(32), .ADDR_W(13), .ACC_CYC(1), .BURST_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_ack(a_m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_ack(a_m1_ack),
    .rdata(a_rdata), .s_sel(a_s_sel), .s_we(a_s_we), .s_addr(a_s_addr),
    .s_wdata(a_s_wdata), .s_rdata(s_rdata), .busy(a_busy)
  );

  xbus_arb #(.DATA_W(32), .ADDR_W(13), .ACC_CYC(3), .BURST_MAX(4)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_ack(b_m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_ack(b_m1_ack),
    .rdata(b_rdata), .s_sel(b_s_sel), .s_we(b_s_we), .s_addr(b_s_addr),
    .s_wdata(b_s_wdata), .s_rdata(s_rdata), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reset pulse placed between edges
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  logic exp_own [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int sel_cnt, ack_cnt, ack1_cnt;

    // ---- reset state ----
    #12;
    chk("rst_busy",  32'(a_busy),  32'd0);
    chk("rst_sel",   32'(a_s_sel), 32'd0);
    chk("rst_rdata", a_rdata,      32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ---- test 1: reset mid-ACC (instance b, ACC_CYC=3) ----
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 13'h020;
    tick();
    tick();
    chk("t1_sel_before", 32'(b_s_sel),  32'd1);
    chk("t1_gnt_before", 32'(b_m0_gnt), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t1_sel_async", 32'(b_s_sel),  32'd0);
    chk("t1_gnt_async", 32'(b_m0_gnt), 32'd0);
    chk("t1_ack_async", 32'(b_m0_ack), 32'd0);
    m0_req = 1'b0;
    rst = 1'b1;
    tick();
    chk("t1_busy_after", 32'(b_busy), 32'd0);
    chk("t1_sel_after",  32'(b_s_sel), 32'd0);

    // ---- test 2: m0 read, instance a ----
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 13'h010; s_rdata = 32'hDEADBEEF;
    tick();
    chk("t2_sel",    32'(a_s_sel),  32'd1);
    chk("t2_addr",   32'(a_s_addr), 32'h010);
    chk("t2_we",     32'(a_s_we),   32'd0);
    chk("t2_gnt",    32'(a_m0_gnt), 32'd1);
    chk("t2_busy",   32'(a_busy),   32'd1);
    tick();
    chk("t2_ack",    32'(a_m0_ack), 32'd1);
    chk("t2_m1ack",  32'(a_m1_ack), 32'd0);
    chk("t2_rdata",  a_rdata,       32'hDEADBEEF);
    chk("t2_seloff", 32'(a_s_sel),  32'd0);
    m0_req = 1'b0;
    tick();
    chk("t2_ack_end", 32'(a_m0_ack), 32'd0);
    chk("t2_gnt_end", 32'(a_m0_gnt), 32'd0);
    chk("t2_idle",    32'(a_busy),   32'd0);
    tick();
    chk("t2_norepeat", 32'(a_s_sel), 32'd0);

    // ---- test 3: m1 write, instance a ----
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 13'h7FF; m1_wdata = 32'h12345678;
    s_rdata = 32'hA5A5A5A5;
    tick();
    chk("t3_we",    32'(a_s_we),    32'd1);
    chk("t3_addr",  32'(a_s_addr),  32'h7FF);
    chk("t3_wdata", a_s_wdata,      32'h12345678);
    chk("t3_gnt",   32'({a_m1_gnt, a_m0_gnt}), 32'd2);
    tick();
    chk("t3_ack",   32'({a_m1_ack, a_m0_ack}), 32'd2);
    chk("t3_rdata_hold", a_rdata, 32'hDEADBEEF);
    chk("t3_we_off", 32'(a_s_we), 32'd0);
    m1_req = 1'b0; m1_we = 1'b0;
    tick();
    chk("t3_addr_keep", 32'(a_s_addr), 32'h7FF);
    chk("t3_ack_end",   32'({a_m1_ack, a_m0_ack}), 32'd0);

    // ---- test 4: both request continuously, BURST_MAX=4 ----
    do_reset();
    m0_req = 1'b1; m0_addr = 13'h100;
    m1_req = 1'b1; m1_addr = 13'h200;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("t4_gnt%0d", i), 32'({a_m1_gnt, a_m0_gnt}),
          exp_own[i] ? 32'd2 : 32'd1);
      chk($sformatf("t4_addr%0d", i), 32'(a_s_addr),
          exp_own[i] ? 32'h200 : 32'h100);
      tick();
      chk($sformatf("t4_ack%0d", i), 32'({a_m1_ack, a_m0_ack}),
          exp_own[i] ? 32'd2 : 32'd1);
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    // ---- test 5: ACC_CYC=3, m0 drops req mid-access ----
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 13'h044; s_rdata = 32'h0BADF00D;
    sel_cnt = 0; ack_cnt = 0; ack1_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) m0_req = 1'b0;
      sel_cnt  += int'(b_s_sel);
      ack_cnt  += int'(b_m0_ack);
      ack1_cnt += int'(b_m1_ack);
    end
    chk("t5_sel_cycles", 32'(sel_cnt),  32'd3);
    chk("t5_ack_pulses", 32'(ack_cnt),  32'd1);
    chk("t5_m1_ack",     32'(ack1_cnt), 32'd0);
    chk("t5_rdata",      b_rdata,       32'h0BADF00D);
    chk("t5_idle",       32'(b_busy),   32'd0);

    // ---- test 6: first tie after reset, then lone m1 uncapped ----
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    chk("t6_tie_gnt", 32'({a_m1_gnt, a_m0_gnt}), 32'd1);
    tick();
    m0_req = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t6_solo%0d", i), 32'({a_m1_gnt, a_m0_gnt}), 32'd2);
      tick();
      tick();
    end
    m0_req = 1'b1;
    tick();
    chk("t6_cap_handover", 32'({a_m1_gnt, a_m0_gnt}), 32'd1);
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    tick();
    chk("t6_idle", 32'(a_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
